// File: rtl/systolic_pkg.sv
// Shared types and packing helpers for the systolic job scheduler and its lane selector.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPTURE,
    DONE
  } state_t;

  localparam int N_DEF  = 3;
  localparam int T_LAST = 3 * N_DEF - 3;

  // Element positions inside the flattened A, B and C buses.
  function automatic int idx_a(input int i, input int k, input int n);
    return i * n + k;
  endfunction

  function automatic int idx_b(input int k, input int j, input int n);
    return k * n + j;
  endfunction

  function automatic int idx_c(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/systolic_skew_sel.sv
// Combinational skew selector: picks the diagonal wavefront of A and B for step t.
module systolic_skew_sel
  import systolic_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 3,
  parameter int CW = 3
) (
  input  logic               i_run,
  input  logic [CW-1:0]      i_t,
  input  logic [W*N*N-1:0]   i_a,
  input  logic [W*N*N-1:0]   i_b,
  output logic [W*N-1:0]     o_lane_a,
  output logic [W*N-1:0]     o_lane_b
);

  // Lane i carries element k = t - i of its row (A) or column (B); outside the window it is 0.
  always_comb begin
    o_lane_a = '0;
    o_lane_b = '0;
    if (i_run) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(i_t) == i + k) begin
            o_lane_a[i*W +: W] = i_a[idx_a(i, k, N)*W +: W];
            o_lane_b[i*W +: W] = i_b[idx_b(k, i, N)*W +: W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/systolic_sched.sv
// Job-level scheduler: latches one A/B job, clears and feeds the array for a bounded
// number of steps, then captures and presents the result through a valid/ready handshake.
module systolic_sched
  import systolic_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start_valid,
  output logic                 o_start_ready,
  input  logic [W*N*N-1:0]     i_A,
  input  logic [W*N*N-1:0]     i_B,
  output logic                 o_arr_en,
  output logic                 o_arr_clr,
  output logic [W*N-1:0]       o_arr_A,
  output logic [W*N-1:0]       o_arr_B,
  input  logic [2*W*N*N-1:0]   i_arr_C,
  output logic [2*W*N*N-1:0]   o_C,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy
);

  localparam int T_END = (N == N_DEF) ? T_LAST : 3 * N - 3;
  localparam int CW    = $clog2(3 * N - 2);

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_t;
  logic [W*N*N-1:0]    r_a;
  logic [W*N*N-1:0]    r_b;
  logic [2*W*N*N-1:0]  r_c;
  logic                w_run;
  logic                w_run_last;

  assign w_run      = (r_state == RUN);
  assign w_run_last = w_run && (r_t == CW'(T_END));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start_valid) w_next = CLEAR;
      CLEAR:   w_next = RUN;
      RUN:     if (w_run_last) w_next = CAPTURE;
      CAPTURE: w_next = DONE;
      DONE:    if (i_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_start_ready = 1'b0;
    o_arr_en      = 1'b0;
    o_arr_clr     = 1'b0;
    o_valid       = 1'b0;
    o_busy        = 1'b1;
    unique case (r_state)
      IDLE: begin
        o_start_ready = 1'b1;
        o_busy        = 1'b0;
      end
      CLEAR:   o_arr_clr = 1'b1;
      RUN:     o_arr_en  = 1'b1;
      CAPTURE: o_arr_en  = 1'b0;
      DONE:    o_valid   = 1'b1;
      default: o_busy    = 1'b1;
    endcase
  end

  // Step counter only advances inside RUN and is parked at 0 everywhere else.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_t <= '0;
    end else if (w_run && !w_run_last) begin
      r_t <= r_t + 1'b1;
    end else begin
      r_t <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (r_state == IDLE && i_start_valid) begin
      r_a <= i_A;
      r_b <= i_B;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c <= '0;
    end else if (r_state == CAPTURE) begin
      r_c <= i_arr_C;
    end
  end

  assign o_C = r_c;

  systolic_skew_sel #(
    .W  (W),
    .N  (N),
    .CW (CW)
  ) u_skew (
    .i_run    (w_run),
    .i_t      (r_t),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_lane_a (o_arr_A),
    .o_lane_b (o_arr_B)
  );

endmodule
